// File: rtl/vga_text_link_ctrl.sv
// FIFO-buffered command sequencer for the wclk/d0/dc/cs text display link.
// Define VGA_LINK_CLS_EN to expand CLS into a full-screen clear sequence.
module vga_text_link_ctrl #(
  parameter int WCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       wclk,
  output logic       d0,
  output logic       dc,
  output logic       cs
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (WCLK_DIV > 1) ? $clog2(WCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(WCLK_DIV - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  localparam logic [1:0] T_CHAR = 2'd0;
  localparam logic [1:0] T_ROW  = 2'd1;
  localparam logic [1:0] T_CLS  = 2'd2;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_s, pop_s, load_s;
  logic [1:0]    head_type_s;
  logic [7:0]    head_data_s;

  logic [1:0]    state_q, state_d;
  logic          init_q, init_d;
  logic          wclk_q, wclk_d;
  logic [DW-1:0] div_q, div_d;
  logic          d0_q, d0_d, dc_q, dc_d, cs_q, cs_d;
  logic [7:0]    sr_q, sr_d;
  logic [3:0]    bits_q, bits_d;
  logic          ready_q, busy_q;
  logic          pulse_end_s, rise_s;
  logic          frm_load_s, frm_char_s;
  logic [7:0]    frm_byte_s;

`ifdef VGA_LINK_CLS_EN
  localparam logic [12:0] CLS_LAST = 13'd4801;
  localparam logic [12:0] CLS_PRE  = 13'd4800;
  logic          cls_act_q, cls_act_d;
  logic [12:0]   cls_cnt_q, cls_cnt_d;
`endif

  assign push_s      = cmd_valid && ready_q;
  assign head_type_s = mem_q[rd_ptr_q][9:8];
  assign head_data_s = mem_q[rd_ptr_q][7:0];
  assign pulse_end_s = wclk_q && (div_q == DIV_LAST);
  assign rise_s      = !wclk_q && (div_q == DIV_LAST);

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign wclk      = wclk_q;
  assign d0        = d0_q;
  assign dc        = dc_q;
  assign cs        = cs_q;

  // Command storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk25) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_type, cmd_data};
    end
  end

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Link sequencer: pulse timing, shift/latch framing and FIFO pops.
  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    wclk_d     = wclk_q;
    div_d      = div_q;
    d0_d       = d0_q;
    dc_d       = dc_q;
    cs_d       = cs_q;
    sr_d       = sr_q;
    bits_d     = bits_q;
    pop_s      = 1'b0;
    load_s     = 1'b0;
    frm_load_s = 1'b0;
    frm_char_s = 1'b0;
    frm_byte_s = 8'd0;
`ifdef VGA_LINK_CLS_EN
    cls_act_d  = cls_act_q;
    cls_cnt_d  = cls_cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
        init_d  = 1'b1;
        cs_d    = 1'b0;
        dc_d    = 1'b1;
        d0_d    = 1'b0;
        sr_d    = 8'd0;
        bits_d  = 4'd8;
        wclk_d  = 1'b0;
        div_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_IDLE: begin
        if (count_q != '0) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT, ST_LATCH: begin
        if (pulse_end_s) begin
          wclk_d = 1'b0;
          div_d  = '0;
          if (state_q == ST_SHIFT) begin
            if (bits_q == 4'd1) begin
              dc_d    = 1'b0;
              state_d = ST_LATCH;
            end else begin
              bits_d = bits_q - 4'd1;
              sr_d   = {1'b0, sr_q[7:1]};
              d0_d   = sr_q[1];
            end
          end else if (init_q) begin
            init_d  = 1'b0;
            state_d = ST_IDLE;
          end
`ifdef VGA_LINK_CLS_EN
          else if (cls_act_q && (cls_cnt_q != CLS_LAST)) begin
            // Frame 0 and frame 4801 are ROW 0, everything between is a space.
            cls_cnt_d  = cls_cnt_q + 13'd1;
            frm_load_s = 1'b1;
            frm_char_s = (cls_cnt_q != CLS_PRE);
            frm_byte_s = (cls_cnt_q != CLS_PRE) ? 8'h20 : 8'h00;
          end
`endif
          else begin
`ifdef VGA_LINK_CLS_EN
            cls_act_d = 1'b0;
`endif
            if (count_q != '0) begin
              load_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (rise_s) begin
          wclk_d = 1'b1;
          div_d  = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      pop_s = 1'b1;
      case (head_type_s)
        T_CHAR: begin
          frm_load_s = 1'b1;
          frm_char_s = 1'b1;
          frm_byte_s = head_data_s;
        end
        T_ROW: begin
          frm_load_s = 1'b1;
          frm_char_s = 1'b0;
          frm_byte_s = {1'b0, head_data_s[6:0]};
        end
        T_CLS: begin
`ifdef VGA_LINK_CLS_EN
          cls_act_d  = 1'b1;
          cls_cnt_d  = 13'd0;
          frm_load_s = 1'b1;
          frm_char_s = 1'b0;
          frm_byte_s = 8'd0;
`else
          state_d = ST_IDLE;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end

    if (frm_load_s) begin
      cs_d    = frm_char_s;
      dc_d    = 1'b1;
      d0_d    = frm_byte_s[0];
      sr_d    = frm_byte_s;
      bits_d  = frm_char_s ? 4'd8 : 4'd7;
      wclk_d  = 1'b0;
      div_d   = '0;
      state_d = ST_SHIFT;
    end else begin
      bits_d = bits_d;
    end
  end

  // State, link outputs and handshake flags, all registered.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_INIT;
      init_q    <= 1'b1;
      wclk_q    <= 1'b0;
      div_q     <= '0;
      d0_q      <= 1'b0;
      dc_q      <= 1'b0;
      cs_q      <= 1'b0;
      sr_q      <= 8'd0;
      bits_q    <= 4'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
`ifdef VGA_LINK_CLS_EN
      cls_act_q <= 1'b0;
      cls_cnt_q <= 13'd0;
`endif
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      state_q   <= state_d;
      init_q    <= init_d;
      wclk_q    <= wclk_d;
      div_q     <= div_d;
      d0_q      <= d0_d;
      dc_q      <= dc_d;
      cs_q      <= cs_d;
      sr_q      <= sr_d;
      bits_q    <= bits_d;
      ready_q   <= (count_d != CNT_FULL) && !init_d;
      busy_q    <= (count_d != '0) || (state_d != ST_IDLE);
`ifdef VGA_LINK_CLS_EN
      cls_act_q <= cls_act_d;
      cls_cnt_q <= cls_cnt_d;
`endif
    end
  end
endmodule
